// File: rtl/sccb_init_seq.sv
// Camera register-init sequencer: walks a sync ROM table, issues SCCB writes, waits ms delays, stops on FFFF.
// Latency: FETCH + DECODE + ISSUE (3 cycles min) per write entry plus the master's transaction time.
// Backpressure: sccb_valid and write data are held until sccb_ready; optional NACK retries under `SCCB_INIT_RETRY_EN.
module sccb_init_seq #(
    parameter int          NUM_ENTRIES   = 64,
    parameter logic [7:0]  DEV_ADDR      = 8'h42,
    parameter int          CYCLES_PER_MS = 100000,
    parameter int          MAX_RETRY     = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        sccb_valid,
    input  logic        sccb_ready,
    output logic [7:0]  sccb_dev_addr,
    output logic [7:0]  sccb_reg_addr,
    output logic [7:0]  sccb_wdata,
    input  logic        sccb_done,
    input  logic        sccb_nack,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  err_idx
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, ISSUE, WAIT_DONE, DELAY, FINISH, ERROR
    } state_t;

    localparam logic [8:0]  LAST_IDX = 9'(NUM_ENTRIES);
    localparam logic [31:0] CPM      = 32'(CYCLES_PER_MS);

    state_t      state;
    logic [8:0]  index;
    logic [8:0]  index_nxt;
    logic [31:0] dly_cnt;
    logic        xfer_done;

`ifdef SCCB_INIT_RETRY_EN
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RW-1:0] retry_cnt;
`endif

    assign sccb_dev_addr = DEV_ADDR;
    assign index_nxt     = index + 9'd1;

    // Completion may coincide with the ready handshake; treat both the same way.
    assign xfer_done = sccb_done &&
                       ((state == WAIT_DONE) || ((state == ISSUE) && sccb_ready));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            index         <= '0;
            dly_cnt       <= '0;
            rom_addr      <= '0;
            sccb_valid    <= 1'b0;
            sccb_reg_addr <= '0;
            sccb_wdata    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            err_idx       <= '0;
`ifdef SCCB_INIT_RETRY_EN
            retry_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        index    <= '0;
                        rom_addr <= '0;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        state    <= FETCH;
`ifdef SCCB_INIT_RETRY_EN
                        retry_cnt <= '0;
`endif
                    end
                end
                FETCH: begin
                    rom_addr <= index[7:0];
                    state    <= DECODE;
                end
                DECODE: begin
                    if (index == LAST_IDX || rom_data == 16'hFFFF) begin
                        state <= FINISH;
                    end else if (rom_data[15:8] == 8'hF0) begin
                        dly_cnt <= 32'(rom_data[7:0]) * CPM;
                        state   <= DELAY;
                    end else begin
                        sccb_reg_addr <= rom_data[15:8];
                        sccb_wdata    <= rom_data[7:0];
                        sccb_valid    <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sccb_ready) begin
                        sccb_valid <= 1'b0;
                        state      <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                end
                DELAY: begin
                    if (dly_cnt == '0) begin
                        index    <= index_nxt;
                        rom_addr <= index_nxt[7:0];
                        state    <= FETCH;
                    end else begin
                        dly_cnt <= dly_cnt - 32'd1;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                ERROR: begin
                    err     <= 1'b1;
                    err_idx <= index[7:0];
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (xfer_done) begin
                if (!sccb_nack) begin
                    index    <= index_nxt;
                    rom_addr <= index_nxt[7:0];
                    state    <= FETCH;
`ifdef SCCB_INIT_RETRY_EN
                    retry_cnt <= '0;
`endif
                end else begin
`ifdef SCCB_INIT_RETRY_EN
                    // Re-issue the same latched write until the retry budget is spent.
                    if (retry_cnt < RW'(MAX_RETRY)) begin
                        retry_cnt  <= retry_cnt + 1'b1;
                        sccb_valid <= 1'b1;
                        state      <= ISSUE;
                    end else begin
                        sccb_valid <= 1'b0;
                        state      <= ERROR;
                    end
`else
                    sccb_valid <= 1'b0;
                    state      <= ERROR;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_sccb_init_seq.sv
// Directed bench for sccb_init_seq: sync ROM model, SCCB master model with programmable ready/done timing and NACKs.
module tb_sccb_init_seq;

    localparam int CPM = 20;

    logic        clk = 1'b0;
    logic        rstn, start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        sccb_valid, sccb_ready;
    logic [7:0]  sccb_dev_addr, sccb_reg_addr, sccb_wdata;
    logic        sccb_done, sccb_nack;
    logic        busy, done, err;
    logic [7:0]  err_idx;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sccb_init_seq #(
        .NUM_ENTRIES(4), .DEV_ADDR(8'h42), .CYCLES_PER_MS(CPM), .MAX_RETRY(3)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .sccb_valid(sccb_valid), .sccb_ready(sccb_ready),
        .sccb_dev_addr(sccb_dev_addr), .sccb_reg_addr(sccb_reg_addr), .sccb_wdata(sccb_wdata),
        .sccb_done(sccb_done), .sccb_nack(sccb_nack),
        .busy(busy), .done(done), .err(err), .err_idx(err_idx)
    );

    logic [15:0] rom [0:255];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Master model state and transfer log
    int         m_rd = 2, m_dd = 10, nack_left = 0;
    int         ph = 0, wcnt = 0, xfer_cnt = 0;
    logic [7:0] cur_reg;
    logic [7:0] log_reg [0:31];
    logic [7:0] log_dat [0:31];
    logic [7:0] log_dev [0:31];

    task automatic fire_done();
        sccb_done = 1'b1;
        if (cur_reg == 8'h13 && nack_left > 0) begin
            sccb_nack = 1'b1;
            nack_left--;
        end else begin
            sccb_nack = 1'b0;
        end
    endtask

    initial begin
        sccb_ready = 1'b0; sccb_done = 1'b0; sccb_nack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                sccb_ready = 1'b0; sccb_done = 1'b0; sccb_nack = 1'b0; ph = 0; wcnt = 0;
            end else begin
                if (sccb_done) begin sccb_done = 1'b0; sccb_nack = 1'b0; end
                if (sccb_ready) begin
                    sccb_ready = 1'b0;
                    ph = (m_dd == 0) ? 0 : 1;
                    wcnt = 0;
                end else if (ph == 1) begin
                    wcnt++;
                    if (wcnt >= m_dd) begin fire_done(); ph = 0; wcnt = 0; end
                end else if (sccb_valid === 1'b1) begin
                    wcnt++;
                    if (wcnt >= m_rd) begin
                        sccb_ready = 1'b1;
                        cur_reg = sccb_reg_addr;
                        if (xfer_cnt < 32) begin
                            log_reg[xfer_cnt] = sccb_reg_addr;
                            log_dat[xfer_cnt] = sccb_wdata;
                            log_dev[xfer_cnt] = sccb_dev_addr;
                        end
                        xfer_cnt++;
                        if (m_dd == 0) fire_done();
                        wcnt = 0;
                    end
                end
            end
        end
    end

    // Valid-phase monitor: high-cycle count, payload stability, first assertion time
    int         vld_hi = 0, viol = 0, first_vld = -1;
    logic [7:0] s_reg, s_dat;
    logic       prev_vld = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (sccb_valid === 1'b1) begin
                vld_hi++;
                if (prev_vld && (sccb_reg_addr !== s_reg || sccb_wdata !== s_dat)) viol++;
                s_reg = sccb_reg_addr;
                s_dat = sccb_wdata;
                if (first_vld < 0) first_vld = cyc;
            end
            prev_vld = (sccb_valid === 1'b1);
        end
    end

    int t_start;

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        xfer_cnt = 0; vld_hi = 0; viol = 0; first_vld = -1; nack_left = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1; t_start = cyc;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (busy === 1'b0) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (sccb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", sccb_valid); end
        n_cmp++; if (rom_addr !== 8'h00) begin n_bad++; $display("FAIL reset_rom_addr: got %h want 00", rom_addr); end
        n_cmp++; if (err_idx !== 8'h00) begin n_bad++; $display("FAIL reset_err_idx: got %h want 00", err_idx); end
        n_cmp++; if (sccb_dev_addr !== 8'h42) begin n_bad++; $display("FAIL reset_dev_addr: got %h want 42", sccb_dev_addr); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        clear_rom();
        rom[0] = 16'h1280; rom[1] = 16'h1101;
        m_rd = 2; m_dd = 10;
        pulse_start();
        wait_idle(2000, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_timeout: busy still %b want 0", busy); end
        n_cmp++; if (xfer_cnt !== 2) begin n_bad++; $display("FAIL basic_count: got %0d want 2", xfer_cnt); end
        n_cmp++; if ({log_dev[0], log_reg[0], log_dat[0]} !== 24'h421280) begin n_bad++;
            $display("FAIL basic_wr0: got %h want 421280", {log_dev[0], log_reg[0], log_dat[0]}); end
        n_cmp++; if ({log_dev[1], log_reg[1], log_dat[1]} !== 24'h421101) begin n_bad++;
            $display("FAIL basic_wr1: got %h want 421101", {log_dev[1], log_reg[1], log_dat[1]}); end
        n_cmp++; if ({done, busy, err} !== 3'b100) begin n_bad++;
            $display("FAIL basic_status: done/busy/err got %b want 100", {done, busy, err}); end
    endtask

    task automatic test_delay();
        bit ok;
        int gap;
        clear_rom();
        rom[0] = 16'hF005; rom[1] = 16'h1234;
        m_rd = 1; m_dd = 3;
        pulse_start();
        wait_idle(2000, ok);
        gap = first_vld - (t_start + 2);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL delay_timeout: busy still %b want 0", busy); end
        n_cmp++; if (first_vld < 0 || gap < 5 * CPM || gap > 5 * CPM + 10) begin n_bad++;
            $display("FAIL delay_gap: got %0d cycles want %0d..%0d", gap, 5 * CPM, 5 * CPM + 10); end
        n_cmp++; if (xfer_cnt !== 1 || {log_reg[0], log_dat[0]} !== 16'h1234) begin n_bad++;
            $display("FAIL delay_write: got %0d writes first %h want 1 write 1234", xfer_cnt, {log_reg[0], log_dat[0]}); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL delay_done: got %b want 1", done); end
    endtask

    task automatic test_stall();
        bit ok;
        clear_rom();
        rom[0] = 16'h1280;
        m_rd = 50; m_dd = 3;
        pulse_start();
        wait_idle(2000, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_timeout: busy still %b want 0", busy); end
        n_cmp++; if (vld_hi !== 50) begin n_bad++; $display("FAIL stall_valid_cycles: got %0d want 50", vld_hi); end
        n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL stall_stable: got %0d changes want 0", viol); end
        n_cmp++; if (xfer_cnt !== 1) begin n_bad++; $display("FAIL stall_count: got %0d want 1", xfer_cnt); end
    endtask

    task automatic test_nack();
        bit ok;
        int hi_end, n13;
        clear_rom();
        rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'h1322; rom[3] = 16'h1433;
        m_rd = 1; m_dd = 4; nack_left = 2;
        pulse_start();
        wait_idle(2000, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL nack_timeout: busy still %b want 0", busy); end
        hi_end = vld_hi;
        repeat (20) @(negedge clk);
        n13 = 0;
        for (int i = 0; i < xfer_cnt && i < 32; i++) if (log_reg[i] == 8'h13) n13++;
`ifdef SCCB_INIT_RETRY_EN
        n_cmp++; if ({done, err} !== 2'b10) begin n_bad++; $display("FAIL nack_status: done/err got %b want 10", {done, err}); end
        n_cmp++; if (n13 !== 3) begin n_bad++; $display("FAIL nack_issues: entry 2 issued %0d want 3", n13); end
        n_cmp++; if (xfer_cnt !== 6) begin n_bad++; $display("FAIL nack_count: got %0d want 6", xfer_cnt); end
`else
        n_cmp++; if ({done, err} !== 2'b01) begin n_bad++; $display("FAIL nack_status: done/err got %b want 01", {done, err}); end
        n_cmp++; if (err_idx !== 8'd2) begin n_bad++; $display("FAIL nack_err_idx: got %0d want 2", err_idx); end
        n_cmp++; if (xfer_cnt !== 3 || n13 !== 1) begin n_bad++;
            $display("FAIL nack_count: got %0d writes %0d of entry 2 want 3 and 1", xfer_cnt, n13); end
`endif
        n_cmp++; if (vld_hi !== hi_end) begin n_bad++; $display("FAIL nack_quiet: valid cycles %0d want %0d", vld_hi, hi_end); end
        nack_left = 0;
    endtask

    task automatic test_no_end();
        bit ok;
        clear_rom();
        for (int i = 0; i < 8; i++) rom[i] = 16'h1001 + 16'(i);
        m_rd = 1; m_dd = 2;
        pulse_start();
        wait_idle(2000, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL noend_timeout: busy still %b want 0", busy); end
        n_cmp++; if (xfer_cnt !== 4) begin n_bad++; $display("FAIL noend_count: got %0d want 4", xfer_cnt); end
        n_cmp++; if ({log_reg[3], log_dat[3]} !== 16'h1004) begin n_bad++;
            $display("FAIL noend_last: got %h want 1004", {log_reg[3], log_dat[3]}); end
        n_cmp++; if ({done, err} !== 2'b10) begin n_bad++; $display("FAIL noend_status: done/err got %b want 10", {done, err}); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        clear_rom();
        rom[0] = 16'h1280; rom[1] = 16'h1101;
        m_rd = 1; m_dd = 30;
        pulse_start();
        n = 0;
        while (xfer_cnt < 1 && n < 200) begin @(negedge clk); n++; end
        n_cmp++; if (xfer_cnt !== 1) begin n_bad++; $display("FAIL rstmid_first: got %0d writes want 1", xfer_cnt); end
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_cmp++; if (sccb_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", sccb_valid); end
        @(negedge clk);
        rstn = 1'b1;
        xfer_cnt = 0;
        m_dd = 15;
        pulse_start();
        n = 0;
        while (xfer_cnt < 1 && n < 200) begin @(negedge clk); n++; end
        pulse_start();
        wait_idle(2000, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstmid_timeout: busy still %b want 0", busy); end
        n_cmp++; if (xfer_cnt !== 2 || log_reg[0] !== 8'h12 || log_reg[1] !== 8'h11) begin n_bad++;
            $display("FAIL rstmid_writes: got %0d writes regs %h %h want 2 regs 12 11", xfer_cnt, log_reg[0], log_reg[1]); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL rstmid_done: got %b want 1", done); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_rom();
        rom[0] = 16'h1280; rom[1] = 16'h1101;
        m_rd = 1; m_dd = 0;
        for (int r = 0; r < 2; r++) begin
            pulse_start();
            n_cmp++; if ({busy, done, err} !== 3'b100) begin n_bad++;
                $display("FAIL b2b_accept%0d: busy/done/err got %b want 100", r, {busy, done, err}); end
            wait_idle(2000, ok);
            n_cmp++; if (!ok || {done, err} !== 2'b10) begin n_bad++;
                $display("FAIL b2b_end%0d: idle %b done/err %b want 1 10", r, ok, {done, err}); end
        end
        n_cmp++; if (xfer_cnt !== 4 || {log_reg[3], log_dat[3]} !== 16'h1101) begin n_bad++;
            $display("FAIL b2b_writes: got %0d last %h want 4 last 1101", xfer_cnt, {log_reg[3], log_dat[3]}); end
    endtask

    initial begin
        rstn = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        test_reset();
        test_basic();
        test_delay();
        test_stall();
        test_nack();
        test_no_end();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sccb_init_seq.md
Name: sccb_init_seq

Overview:
- Register-initialisation sequencer directly upstream of the SCCB master engine.
- Walks an external synchronous table of camera register writes and issues one SCCB write per entry over a valid/ready plus done handshake.
- Inserts millisecond delays on delay entries, stops on an end marker, and reports done or error to the system/MicroBlaze side.

Parameters:
- NUM_ENTRIES, 64: table depth; the index wraps never, and reaching this count ends the sequence.
- DEV_ADDR, 8'h42: SCCB write ID driven on sccb_dev_addr.
- CYCLES_PER_MS, 100000: clk cycles per millisecond (100 MHz).
- MAX_RETRY, 3: retries per entry on NACK (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- start  in  1  single-cycle pulse; begins the sequence from entry 0
- rom_addr  out  8  table index
- rom_data  in  16  table word, valid 1 cycle after rom_addr; [15:8]=reg addr, [7:0]=data
- sccb_valid  out  1  write request to the SCCB master
- sccb_ready  in  1  master accepts the request
- sccb_dev_addr  out  8  device ID, equal to DEV_ADDR
- sccb_reg_addr  out  8  register address
- sccb_wdata  out  8  register data
- sccb_done  in  1  1-cycle pulse when the write completes
- sccb_nack  in  1  qualified by sccb_done; 1 means the slave did not ACK
- busy  out  1  sequence in progress
- done  out  1  sequence finished OK; level signal
- err  out  1  sequence aborted on NACK; level signal
- err_idx  out  8  index of the failing entry

Behaviour:
- Reset: one clock, rstn synchronous active-low.
  - Reset values: all outputs 0; sccb_dev_addr=DEV_ADDR; state IDLE; index 0; delay counter 0.
  - rstn low in any state returns the block to IDLE on the next edge. sccb_valid drops immediately; a transaction in flight on the master is abandoned.
- Entry encoding:
  - 16'hFFFF: end marker.
  - 16'hF0nn: delay of nn ms, where nn=0 means no delay.
  - Anything else: write rom_data[15:8] <= rom_data[7:0].
- States:
  - IDLE: busy=0.
    - On start: index<=0, done<=0, err<=0, go to FETCH.
    - start is ignored in all other states.
  - FETCH: rom_addr<=index, then go to DECODE next cycle. The ROM has 1-cycle latency, so DECODE samples rom_data.
  - DECODE:
    - If index==NUM_ENTRIES or the end marker: go to FINISH.
    - If a delay entry: load counter nn*CYCLES_PER_MS (32-bit product) and go to DELAY.
    - Otherwise: latch reg/data, assert sccb_valid, go to ISSUE.
  - ISSUE: hold sccb_valid and the data stable until a cycle with sccb_ready=1. That cycle is the transfer; sccb_valid=0 the next cycle, then go to WAIT_DONE.
  - WAIT_DONE: wait for sccb_done.
    - nack=0: index+1, go to FETCH.
    - nack=1: go to ERROR.
    - sccb_done arriving in the same cycle as the ready handshake is legal and is handled as done.
  - DELAY: count down to 0, then index+1 and go to FETCH. A count of 0 goes straight to FETCH on the next cycle.
  - FINISH: done<=1, busy<=0, go to IDLE.
  - ERROR: err<=1, err_idx<=index, busy<=0, go to IDLE.
- busy=1 in every state except IDLE.
- done and err hold until the next accepted start.
- Latency per write entry: 3 cycles of overhead (FETCH, DECODE, ISSUE min) plus the master's transaction time.

Optional Feature:
- Macro: SCCB_INIT_RETRY_EN.
- Defined:
  - On nack=1, if the per-entry retry count is below MAX_RETRY, increment it and go back to ISSUE with the same latched data; otherwise go to ERROR.
  - The retry count clears when the index advances.
- Undefined: the first NACK goes straight to ERROR, and MAX_RETRY is unused.

Test Plan:
- 3-entry table {1280, 1101, FFFF}, master acks with ready after 2 cycles and done after 10 → two writes with reg=12 data=80 then reg=11 data=01, each dev_addr=42; then done=1, busy=0, err=0.
- Table {F005, 1234, FFFF} → the SCCB write starts no earlier than 500000 cycles after DECODE of entry 0.
- sccb_ready held low for 50 cycles → sccb_valid and the data stay stable all 50 cycles; exactly one transfer.
- NACK on entry 2, macro undefined → err=1, err_idx=2, done=0, no further sccb_valid. With the macro defined and NACK 2 times then ACK → 3 issues of entry 2, then the sequence completes with done=1.
- Table with no FFFF and NUM_ENTRIES=4 → exactly 4 writes, then done=1.
- rstn low during WAIT_DONE, then start again → busy=0 and sccb_valid=0 after the reset edge; the restart re-issues entry 0; a start pulse while busy has no effect.
